// File: rtl/hazard_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_pkg
// Shared definitions for the pipeline hazard / forwarding controller:
//   - forwarding mux select encodings (EX-stage operand muxes)
//   - hazard FSM state type
//   - register x0 index
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

  // Operand forwarding mux select encodings. 2'b11 is never driven.
  localparam logic [1:0] FWD_REG = 2'b00;  // value read from the register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // value being written back in WB
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in MEM

  // Register x0 is hardwired to zero: never a forwarding source or stall cause.
  localparam int unsigned REG_ZERO = 0;

  // Hazard sequencer states.
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } hz_state_t;

endpackage : hazard_forward_unit_pkg

// File: rtl/forward_select.sv
// -----------------------------------------------------------------------------
// forward_select
// Pure combinational forwarding-source selection for one EX-stage operand.
// The MEM-stage producer is younger than the WB-stage producer, so it wins
// when both target the same register.
// Ports:
//   i_rs           source register of the EX instruction for this operand
//   i_rd_mem       destination register of the MEM-stage instruction
//   i_regwrite_mem MEM-stage instruction writes its destination
//   i_rd_wb        destination register of the WB-stage instruction
//   i_regwrite_wb  WB-stage instruction writes its destination
//   o_sel          FWD_MEM / FWD_WB / FWD_REG
// -----------------------------------------------------------------------------
module forward_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rd_mem,
  input  logic                  i_regwrite_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_wb,
  input  logic                  i_regwrite_wb,
  output logic [1:0]            o_sel
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(REG_ZERO);

  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_mem = i_regwrite_mem && (i_rd_mem != ZERO_REG) && (i_rd_mem == i_rs);
  assign w_hit_wb  = i_regwrite_wb  && (i_rd_wb  != ZERO_REG) && (i_rd_wb  == i_rs);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_mem) begin
      o_sel = FWD_MEM;
    end else if (w_hit_wb) begin
      o_sel = FWD_WB;
    end
  end

endmodule : forward_select

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// Hazard controller for the 5-stage RISC-V pipeline.
//   - EX operand forwarding selects (two forward_select instances)
//   - load-use stalls (LOAD_LATENCY cycles), data-memory wait freezes and
//     branch flushes, sequenced by a three-state FSM
// Priority within a cycle: freeze > branch flush > stall.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   rs1_id_i/rs2_id_i                 sources of the ID instruction
//   rs1_ex_i/rs2_ex_i/rd_ex_i         sources/destination of the EX instruction
//   regwrite_ex_i, memread_ex_i       EX writes rd / EX is a load
//   rd_mem_i, regwrite_mem_i,
//   memread_mem_i, mem_ready_i        MEM-stage destination/controls, dmem done
//   rd_wb_i, regwrite_wb_i            WB-stage destination/write enable
//   branch_taken_i                    redirect resolved in EX
//   fwd_a_sel_o/fwd_b_sel_o           00 regfile, 01 WB, 10 MEM
//   pc_write_o, if_id_write_o         front-end enables
//   id_ex_bubble_o, if_id_flush_o     NOP into ID/EX, clear IF/ID
//   pipe_freeze_o                     hold ID/EX, EX/MEM, MEM/WB
//
// Optional build macro HAZARD_PERF_CNT_EN adds wrapping 32-bit counters
//   stall_cycles_o, freeze_cycles_o, flush_events_o (cleared by reset).
//
// During reset every output takes its idle value (PC and IF/ID enabled,
// everything else 0, forward selects at FWD_REG).
// -----------------------------------------------------------------------------
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_id_i,
  input  logic [REG_ADDR_W-1:0] rs1_ex_i,
  input  logic [REG_ADDR_W-1:0] rs2_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_ex_i,
  input  logic                  regwrite_ex_i,
  input  logic                  memread_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_mem_i,
  input  logic                  regwrite_mem_i,
  input  logic                  memread_mem_i,
  input  logic                  mem_ready_i,
  input  logic [REG_ADDR_W-1:0] rd_wb_i,
  input  logic                  regwrite_wb_i,
  input  logic                  branch_taken_i,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  id_ex_bubble_o,
  output logic                  if_id_flush_o,
  output logic                  pipe_freeze_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           freeze_cycles_o,
  output logic [31:0]           flush_events_o
`endif
);

  if ((LOAD_LATENCY < 1) || (LOAD_LATENCY > 7)) begin : g_bad_latency
    $error("LOAD_LATENCY must be in 1..7");
  end

  localparam logic [REG_ADDR_W-1:0] ZERO_REG  = REG_ADDR_W'(REG_ZERO);
  localparam logic [2:0]            CNT_LOAD  = 3'(LOAD_LATENCY - 1);

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs           (rs1_ex_i),
    .i_rd_mem       (rd_mem_i),
    .i_regwrite_mem (regwrite_mem_i),
    .i_rd_wb        (rd_wb_i),
    .i_regwrite_wb  (regwrite_wb_i),
    .o_sel          (w_fwd_a)
  );

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs           (rs2_ex_i),
    .i_rd_mem       (rd_mem_i),
    .i_regwrite_mem (regwrite_mem_i),
    .i_rd_wb        (rd_wb_i),
    .i_regwrite_wb  (regwrite_wb_i),
    .o_sel          (w_fwd_b)
  );

  // All producer registers are treated as invalid while reset is held.
  assign fwd_a_sel_o = reset ? w_fwd_a : FWD_REG;
  assign fwd_b_sel_o = reset ? w_fwd_b : FWD_REG;

  // ---------------------------------------------------------------------------
  // Hazard FSM
  // ---------------------------------------------------------------------------
  hz_state_t r_state;
  hz_state_t w_state_nxt;
  logic [2:0] r_stall_cnt;
  logic [2:0] w_stall_cnt_nxt;

  logic w_load_use;
  logic w_mem_busy;
  logic w_run_eval;  // cycle in which the pipeline may advance from RUN rules
  logic w_freeze;
  logic w_flush;
  logic w_stall;

  assign w_load_use = memread_ex_i && (rd_ex_i != ZERO_REG) &&
                      ((rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i));
  assign w_mem_busy = memread_mem_i && !mem_ready_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_run_eval      = 1'b0;
    w_freeze        = 1'b0;
    w_flush         = 1'b0;
    w_stall         = 1'b0;

    if (reset) begin
      unique case (r_state)
        ST_RUN: begin
          if (w_mem_busy) begin
            w_freeze    = 1'b1;
            w_state_nxt = ST_MEM_WAIT;
          end else begin
            w_run_eval = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          if (!mem_ready_i) begin
            w_freeze = 1'b1;
          end else begin
            // The pipeline moves again this cycle, so hazards in ID/EX
            // are judged exactly as in RUN.
            w_state_nxt = ST_RUN;
            w_run_eval  = 1'b1;
          end
        end

        ST_LOAD_STALL: begin
          if (w_mem_busy) begin
            // A memory wait during a stall holds the stall count: nothing
            // advances, so no stall cycle is consumed.
            w_freeze = 1'b1;
          end else if (branch_taken_i) begin
            // The waiting consumer is squashed by the redirect.
            w_flush         = 1'b1;
            w_state_nxt     = ST_RUN;
            w_stall_cnt_nxt = 3'd0;
          end else begin
            w_stall         = 1'b1;
            w_stall_cnt_nxt = r_stall_cnt - 3'd1;
            if (r_stall_cnt <= 3'd1) begin
              w_state_nxt = ST_RUN;
            end
          end
        end

        default: begin
          w_state_nxt     = ST_RUN;
          w_stall_cnt_nxt = 3'd0;
        end
      endcase

      if (w_run_eval) begin
        if (branch_taken_i) begin
          w_flush = 1'b1;
        end else if (w_load_use) begin
          w_stall = 1'b1;
          if (LOAD_LATENCY > 1) begin
            w_stall_cnt_nxt = CNT_LOAD;
            w_state_nxt     = ST_LOAD_STALL;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign pc_write_o     = !(w_freeze || w_stall);
  assign if_id_write_o  = !(w_freeze || w_stall);
  assign id_ex_bubble_o = w_stall || w_flush;
  assign if_id_flush_o  = w_flush;
  assign pipe_freeze_o  = w_freeze;

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;
  logic [31:0] r_freeze_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles  <= 32'd0;
      r_freeze_cycles <= 32'd0;
      r_flush_events  <= 32'd0;
    end else begin
      if (w_stall)  r_stall_cycles  <= r_stall_cycles  + 32'd1;
      if (w_freeze) r_freeze_cycles <= r_freeze_cycles + 32'd1;
      if (w_flush)  r_flush_events  <= r_flush_events  + 32'd1;
    end
  end

  assign stall_cycles_o  = r_stall_cycles;
  assign freeze_cycles_o = r_freeze_cycles;
  assign flush_events_o  = r_flush_events;
`endif

endmodule : hazard_forward_unit

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
// Self-checking bench for hazard_forward_unit (LOAD_LATENCY = 3).
// The reference model tracks "extra stall cycles still owed" and "waiting on
// data memory" and derives every output from the hazard rules each cycle.
// Output vector order: {fwd_a[1:0], fwd_b[1:0], pc_write, if_id_write,
//                       id_ex_bubble, if_id_flush, pipe_freeze}.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

  localparam int unsigned LAT = 3;
  localparam int unsigned W   = 5;
  localparam logic [8:0]  IDLE_OUT = 9'b00_00_1_1_0_0_0;

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT inputs
  logic [W-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic         rw_ex, mr_ex, rw_mem, mr_mem, mem_ready, rw_wb, branch;

  // DUT outputs
  logic [1:0] fwd_a, fwd_b;
  logic       pc_write, if_id_write, bubble, flush, freeze;
  logic [8:0] w_obs;
  assign w_obs = {fwd_a, fwd_b, pc_write, if_id_write, bubble, flush, freeze};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, freeze_cycles, flush_events;
`endif

  hazard_forward_unit #(.LOAD_LATENCY(LAT), .REG_ADDR_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .rs1_id_i       (rs1_id),
    .rs2_id_i       (rs2_id),
    .rs1_ex_i       (rs1_ex),
    .rs2_ex_i       (rs2_ex),
    .rd_ex_i        (rd_ex),
    .regwrite_ex_i  (rw_ex),
    .memread_ex_i   (mr_ex),
    .rd_mem_i       (rd_mem),
    .regwrite_mem_i (rw_mem),
    .memread_mem_i  (mr_mem),
    .mem_ready_i    (mem_ready),
    .rd_wb_i        (rd_wb),
    .regwrite_wb_i  (rw_wb),
    .branch_taken_i (branch),
    .fwd_a_sel_o    (fwd_a),
    .fwd_b_sel_o    (fwd_b),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write),
    .id_ex_bubble_o (bubble),
    .if_id_flush_o  (flush),
    .pipe_freeze_o  (freeze)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o  (stall_cycles),
    .freeze_cycles_o (freeze_cycles),
    .flush_events_o  (flush_events)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int stall_left = 0;  // stall cycles still owed after the current one
  bit waiting    = 0;  // parked until data memory answers

  function automatic logic [1:0] model_fwd(input logic [W-1:0] rs);
    if (rw_mem && rd_mem != 0 && rd_mem == rs) return 2'd2;
    if (rw_wb && rd_wb != 0 && rd_wb == rs)    return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit model_load_use();
    return mr_ex && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
  endfunction

  function automatic bit model_freeze();
    return waiting ? !mem_ready : (mr_mem && !mem_ready);
  endfunction

  function automatic logic [8:0] model_out();
    bit frz, fl, st;
    if (!reset) return IDLE_OUT;
    frz = model_freeze();
    fl  = !frz && branch;
    st  = !frz && !fl && (stall_left > 0 || model_load_use());
    return {model_fwd(rs1_ex), model_fwd(rs2_ex), !(frz || st), !(frz || st),
            st || fl, fl, frz};
  endfunction

  // Advance model state at the clock edge using the inputs of that cycle.
  task automatic model_tick();
    if (!reset) begin
      stall_left = 0;
      waiting    = 0;
    end else if (model_freeze()) begin
      if (stall_left == 0) waiting = 1;
    end else begin
      waiting = 0;
      if (branch)                 stall_left = 0;
      else if (stall_left > 0)    stall_left = stall_left - 1;
      else if (model_load_use())  stall_left = int'(LAT) - 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    reset = 1'b1;
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
    {rw_ex, mr_ex, rw_mem, mr_mem, rw_wb, branch} = '0;
    mem_ready = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); model_tick(); #1;
    end
  endtask

  task automatic randomize_inputs(input bit hazards);
    rs1_id = W'($urandom_range(0, 3)); rs2_id = W'($urandom_range(0, 3));
    rs1_ex = W'($urandom_range(0, 3)); rs2_ex = W'($urandom_range(0, 3));
    rd_ex  = W'($urandom_range(0, 3)); rd_mem = W'($urandom_range(0, 3));
    rd_wb  = W'($urandom_range(0, 3));
    rw_ex  = 1'($urandom_range(0, 1)); rw_mem = 1'($urandom_range(0, 1));
    rw_wb  = 1'($urandom_range(0, 1));
    mr_ex  = hazards && ($urandom_range(0, 99) < 30);
    mr_mem = hazards && ($urandom_range(0, 99) < 25);
    mem_ready = !hazards || ($urandom_range(0, 99) < 60);
    branch = hazards && ($urandom_range(0, 99) < 10);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(1'b1);
      rw_mem = 1'b1; rd_mem = 5'd1; rs1_ex = 5'd1; mr_mem = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (w_obs !== IDLE_OUT) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, w_obs, IDLE_OUT);
      end
      @(posedge clk); model_tick(); #1;
    end
    set_idle();
    idle_cycles(1);
  endtask

  task automatic test_forward();
    logic [8:0] exp;
    set_idle();
    rw_mem = 1; rd_mem = 5; rw_wb = 1; rd_wb = 5; rs1_ex = 5;
    @(negedge clk); n_tests++;
    if (fwd_a !== 2'b10) begin
      n_fail++; $display("FAIL fwd_mem_wins got=%b exp=10", fwd_a);
    end
    @(posedge clk); model_tick(); #1;
    rw_mem = 0;
    @(negedge clk); n_tests++;
    if (fwd_a !== 2'b01) begin
      n_fail++; $display("FAIL fwd_wb got=%b exp=01", fwd_a);
    end
    @(posedge clk); model_tick(); #1;
    rw_mem = 1; rd_mem = 0; rs2_ex = 0;
    @(negedge clk); n_tests++;
    if (fwd_b !== 2'b00) begin
      n_fail++; $display("FAIL fwd_x0 got=%b exp=00", fwd_b);
    end
    @(posedge clk); model_tick(); #1;
    for (int i = 0; i < 100; i++) begin
      randomize_inputs(1'b0);
      @(negedge clk); exp = model_out(); n_tests++;
      if (w_obs !== exp) begin
        n_fail++; $display("FAIL fwd_rand cyc=%0d got=%b exp=%b", i, w_obs, exp);
      end
      @(posedge clk); model_tick(); #1;
    end
  endtask

  task automatic test_load_stall();
    logic [8:0] exp;
    logic [3:0] pc_seq;
    pc_seq = 4'b1000;  // cycle i expects pc_write = pc_seq[i]
    set_idle(); idle_cycles(2);
    mr_ex = 1; rw_ex = 1; rd_ex = 7; rs2_id = 7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); exp = model_out(); n_tests += 2;
      if (w_obs !== exp) begin
        n_fail++; $display("FAIL load_stall cyc=%0d got=%b exp=%b", i, w_obs, exp);
      end
      if (pc_write !== pc_seq[i] || bubble !== !pc_seq[i]) begin
        n_fail++;
        $display("FAIL load_stall_pc cyc=%0d got pc=%b bub=%b exp pc=%b", i, pc_write, bubble, pc_seq[i]);
      end
      @(posedge clk); model_tick(); #1;
      mr_ex = 0; rw_ex = 0;  // load has left EX; consumer waits in ID
    end
  endtask

  task automatic test_mem_wait();
    logic [8:0] exp;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] frz_before;
`endif
    set_idle(); idle_cycles(2);
`ifdef HAZARD_PERF_CNT_EN
    frz_before = freeze_cycles;
`endif
    mr_mem = 1; rw_mem = 1; rd_mem = 3; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      @(negedge clk); exp = model_out(); n_tests += 2;
      if (w_obs !== exp) begin
        n_fail++; $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, w_obs, exp);
      end
      if (freeze !== (i < 4)) begin
        n_fail++; $display("FAIL mem_wait_freeze cyc=%0d got=%b exp=%b", i, freeze, (i < 4));
      end
      @(posedge clk); model_tick(); #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    n_tests++;
    if (freeze_cycles - frz_before !== 32'd4) begin
      n_fail++; $display("FAIL perf_freeze got=%0d exp=4", freeze_cycles - frz_before);
    end
`endif
  endtask

  task automatic test_branch_abort();
    logic [8:0] exp;
    logic [8:0] want[3];
    want[0] = 9'b00_00_0_0_1_0_0;  // first stall cycle
    want[1] = 9'b00_00_1_1_1_1_0;  // branch flush, stall aborted
    want[2] = IDLE_OUT;            // back in RUN
    set_idle(); idle_cycles(2);
    mr_ex = 1; rw_ex = 1; rd_ex = 7; rs2_id = 7;
    for (int i = 0; i < 3; i++) begin
      branch = (i == 1);
      @(negedge clk); exp = model_out(); n_tests += 2;
      if (w_obs !== exp) begin
        n_fail++; $display("FAIL branch_abort cyc=%0d got=%b exp=%b", i, w_obs, exp);
      end
      if (w_obs !== want[i]) begin
        n_fail++; $display("FAIL branch_abort_fixed cyc=%0d got=%b exp=%b", i, w_obs, want[i]);
      end
      @(posedge clk); model_tick(); #1;
      mr_ex = 0; rw_ex = 0;
    end
  endtask

  task automatic test_freeze_branch();
    logic [8:0] exp;
    set_idle(); idle_cycles(2);
    mr_mem = 1; mem_ready = 0; branch = 1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      @(negedge clk); exp = model_out(); n_tests += 2;
      if (w_obs !== exp) begin
        n_fail++; $display("FAIL freeze_branch cyc=%0d got=%b exp=%b", i, w_obs, exp);
      end
      if (flush !== (i == 2) || freeze !== (i < 2)) begin
        n_fail++; $display("FAIL freeze_branch_fixed cyc=%0d got flush=%b freeze=%b", i, flush, freeze);
      end
      @(posedge clk); model_tick(); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [8:0] exp;
    set_idle(); idle_cycles(2);
    mr_mem = 1; mem_ready = 0;
    idle_cycles(2);             // now parked waiting on memory
    reset = 0;
    @(negedge clk); n_tests++;
    if (w_obs !== IDLE_OUT) begin
      n_fail++; $display("FAIL reset_in_wait got=%b exp=%b", w_obs, IDLE_OUT);
    end
    @(posedge clk); model_tick(); #1;
    reset = 1; mr_mem = 0;      // memory still not ready, but no load in MEM
    @(negedge clk); exp = model_out(); n_tests += 2;
    if (w_obs !== exp) begin
      n_fail++; $display("FAIL after_reset got=%b exp=%b", w_obs, exp);
    end
    if (w_obs !== IDLE_OUT) begin
      n_fail++; $display("FAIL after_reset_run got=%b exp=%b", w_obs, IDLE_OUT);
    end
    @(posedge clk); model_tick(); #1;
    set_idle();
  endtask

  task automatic test_random();
    logic [8:0] exp;
    set_idle(); idle_cycles(3);
    for (int i = 0; i < 600; i++) begin
      randomize_inputs(1'b1);
      reset = ($urandom_range(0, 99) >= 2);
      @(negedge clk); exp = model_out(); n_tests++;
      if (w_obs !== exp) begin
        n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", i, w_obs, exp);
      end
      @(posedge clk); model_tick(); #1;
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_forward();
    test_load_stall();
    test_mem_wait();
    test_branch_abort();
    test_freeze_branch();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hazard_forward_unit
